// File: rtl/my_srl_pkg.sv
// rtl/my_srl_pkg.sv - shared constants and address-width helper for the SRL FIFO
package my_srl_pkg;

  localparam int SRL_MAX_DEPTH = 32;

  // A 2-entry shift register still needs one address bit.
  function automatic int srl_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/my_srl_mem.sv
// rtl/my_srl_mem.sv - parametric addressable shift register (SRL16E generalisation), no reset
module my_srl_mem
  import my_srl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = srl_aw(DEPTH)
) (
  input  logic             clk_i,
  input  logic             ce_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [AW-1:0]    a_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (ce_i) begin
      mem_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign q_o = mem_q[a_i];

endmodule

// File: rtl/my_srl_fifo.sv
// rtl/my_srl_fifo.sv - FWFT valid/ready FIFO on an addressable shift register
// MY_SRL_FIFO_OUTREG_EN adds a registered head stage (capacity DEPTH+1, latency 2).
module my_srl_fifo
  import my_srl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 2)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int AW = srl_aw(DEPTH);
`ifdef MY_SRL_FIFO_OUTREG_EN
  localparam int CAP_INT = DEPTH + 1;
`else
  localparam int CAP_INT = DEPTH;
`endif
  localparam logic [CW-1:0] CAP = CW'(CAP_INT);

  if (DEPTH < 2 || DEPTH > SRL_MAX_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("my_srl_fifo: DEPTH must be a power of 2 in 2..32");
  end

  logic             push;
  logic             pop;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [AW-1:0]    srl_addr;
  logic [WIDTH-1:0] srl_q;

  // Handshake flags come from registered state only.
  assign in_ready = (count_q != CAP);
  assign full     = ~in_ready;
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  my_srl_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i (CLK),
    .ce_i  (push),
    .d_i   (in_data),
    .a_i   (srl_addr),
    .q_o   (srl_q)
  );

`ifdef MY_SRL_FIFO_OUTREG_EN
  logic [CW-1:0]    srl_cnt_q;
  logic [CW-1:0]    srl_cnt_d;
  logic             head_vld_q;
  logic             head_vld_d;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_d;
  logic             load;

  // Refill the head whenever it is vacant or leaving and the SRL has data.
  assign load     = (srl_cnt_q != '0) & (~head_vld_q | pop);
  assign srl_addr = AW'(srl_cnt_q - 1'b1);

  always_comb begin
    srl_cnt_d  = srl_cnt_q;
    head_vld_d = head_vld_q;
    head_d     = head_q;
    case ({push, load})
      2'b10:   srl_cnt_d = srl_cnt_q + 1'b1;
      2'b01:   srl_cnt_d = srl_cnt_q - 1'b1;
      default: srl_cnt_d = srl_cnt_q;
    endcase
    if (load) begin
      head_vld_d = 1'b1;
      head_d     = srl_q;
    end else if (pop) begin
      head_vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      srl_cnt_q  <= '0;
      head_vld_q <= 1'b0;
      head_q     <= '0;
    end else begin
      srl_cnt_q  <= srl_cnt_d;
      head_vld_q <= head_vld_d;
      head_q     <= head_d;
    end
  end

  assign out_valid = head_vld_q;
  assign out_data  = head_q;
`else
  assign srl_addr  = AW'(count_q - 1'b1);
  assign out_valid = (count_q != '0);
  assign out_data  = srl_q;
`endif

endmodule

// File: tb/tb_my_srl_fifo.sv
// tb/tb_my_srl_fifo.sv - directed and randomized self-checking bench for my_srl_fifo
module tb_my_srl_fifo;

`ifdef MY_SRL_FIFO_OUTREG_EN
  localparam int CAP = 17;
  localparam int LAT = 2;
`else
  localparam int CAP = 16;
  localparam int LAT = 1;
`endif

  logic       CLK       = 1'b0;
  logic       CLR       = 1'b0;
  logic       in_valid  = 1'b0;
  logic       in_ready;
  logic [7:0] in_data   = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [4:0] count;
  logic       full;
  logic       empty;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb [$];

  my_srl_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_one(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_one(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, out_data}, {24'd0, exp});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset asserted between edges must act immediately.
    #2 CLR = 1'b1;
    #1;
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    tick();
    CLR = 1'b0;
    tick();

    // Basic ordering.
    push_one(8'h11);
    push_one(8'h22);
    push_one(8'h33);
    tick();
    chk("three_count", {27'd0, count}, 32'd3);
    chk("three_head", {24'd0, out_data}, 32'h11);
    pop_one("pop1", 8'h11);
    pop_one("pop2", 8'h22);
    pop_one("pop3", 8'h33);
    chk("drained_empty", {31'd0, empty}, 32'd1);
    chk("drained_valid", {31'd0, out_valid}, 32'd0);

    // Fill to capacity, then hold a blocked write.
    for (int i = 0; i < CAP; i++) push_one(8'(i));
    tick();
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
    chk("fill_count", {27'd0, count}, CAP);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("blocked_count", {27'd0, count}, CAP);
    end
    in_valid = 1'b0;
    pop_one("full_pop", 8'h00);
    chk("after_pop_ready", {31'd0, in_ready}, 32'd1);
    chk("after_pop_count", {27'd0, count}, CAP - 1);
    for (int i = 1; i < CAP; i++) pop_one("fill_drain", 8'(i));
    chk("fill_drained", {31'd0, empty}, 32'd1);

    // Concurrent push/pop at count 5.
    for (int i = 0; i < 5; i++) push_one(8'(8'h40 + i));
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_data", {24'd0, out_data}, 32'(8'h40 + i));
      in_valid  = 1'b1;
      in_data   = 8'(8'h45 + i);
      out_ready = 1'b1;
      tick();
      chk("stream_count", {27'd0, count}, 32'd5);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 20; i < 25; i++) pop_one("stream_drain", 8'(8'h40 + i));

    // Write-to-read latency into an empty FIFO.
    push_one(8'hA5);
    chk("lat_edge_n_valid", {31'd0, out_valid}, (LAT == 1) ? 32'd1 : 32'd0);
    tick();
    chk("lat_edge_n1_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_edge_n1_data", {24'd0, out_data}, 32'hA5);
    pop_one("lat_pop", 8'hA5);

    // Asynchronous clear mid-operation.
    for (int i = 0; i < 7; i++) push_one(8'(8'h70 + i));
    chk("pre_clr_count", {27'd0, count}, 32'd7);
    #3 CLR = 1'b1;
    #1;
    chk("clr_count", {27'd0, count}, 32'd0);
    chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("clr_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    CLR = 1'b0;
    push_one(8'h5A);
    tick();
    chk("post_clr_count", {27'd0, count}, 32'd1);
    pop_one("post_clr_pop", 8'h5A);

    // Random traffic against a scoreboard.
    sb.delete();
    for (int c = 0; c < 4000; c++) begin
      logic do_push;
      logic do_pop;
      chk("rnd_count", {27'd0, count}, 32'(sb.size()));
      chk("rnd_in_ready", {31'd0, in_ready}, (sb.size() != CAP) ? 32'd1 : 32'd0);
      if (out_valid && sb.size() == 0) chk("rnd_phantom", 32'd1, 32'd0);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      do_push   = in_valid & in_ready;
      do_pop    = out_valid & out_ready;
      if (do_pop && sb.size() != 0) chk("rnd_data", {24'd0, out_data}, {24'd0, sb[0]});
      @(posedge CLK);
      if (do_pop && sb.size() != 0) void'(sb.pop_front());
      if (do_push) sb.push_back(in_data);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
